// File: rtl/dram_word_port_if.sv
// Bundles the CPU word port and the DRAM controller request/response FIFO port of dram_word_port.
// The master modport is the requester's view; slave is the view of the CPU and controller around it.
interface dram_word_port_if #(
  parameter int BYTE_ADDR_W = 28,
  parameter int REQ_ADDR_W  = 27,
  parameter int LINE_W      = 128
);
  logic                   cpu_valid;
  logic                   cpu_ready;
  logic                   cpu_we;
  logic [BYTE_ADDR_W-1:0] cpu_addr;
  logic [31:0]            cpu_wdata;
  logic [3:0]             cpu_be;
  logic                   cpu_resp_valid;
  logic [31:0]            cpu_rdata;
  logic                   req_en;
  logic                   req_rdy;
  logic                   req_cmd;
  logic [REQ_ADDR_W-1:0]  req_addr;
  logic [LINE_W-1:0]      req_data;
  logic                   rsp_en;
  logic [LINE_W-1:0]      rsp_data;

  modport master (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_be, req_rdy, rsp_en, rsp_data,
    output cpu_ready, cpu_resp_valid, cpu_rdata, req_en, req_cmd, req_addr, req_data
  );

  modport slave (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_be, req_rdy, rsp_en, rsp_data,
    input  cpu_ready, cpu_resp_valid, cpu_rdata, req_en, req_cmd, req_addr, req_data
  );
endinterface

// File: rtl/dram_word_port.sv
// Turns 32-bit CPU loads/stores into 128-bit DRAM line requests; stores are read-modify-write.
// Optional one-line buffer enabled by defining LINE_BUF_EN.
module dram_word_port #(
  parameter int BYTE_ADDR_W = 28,
  parameter int REQ_ADDR_W  = 27,
  parameter int LINE_W      = 128
) (
  input logic              clk,
  input logic              rst_n,
  dram_word_port_if.master bus
);
  localparam int TAG_W = BYTE_ADDR_W - 4;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [1:0]            word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [REQ_ADDR_W-1:0] reqAddr_q, reqAddr_d;
  logic [LINE_W-1:0]     reqData_q, reqData_d;
  logic                  unusedAddrBits;

  assign unusedAddrBits = ^bus.cpu_addr[1:0];

  function automatic logic [LINE_W-1:0] mergeLine(input logic [LINE_W-1:0] line,
                                                  input logic [1:0] word,
                                                  input logic [31:0] wdata,
                                                  input logic [3:0] be);
    logic [LINE_W-1:0] merged;
    merged = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[32*int'(word) + 8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

  function automatic logic [31:0] pickWord(input logic [LINE_W-1:0] line, input logic [1:0] word);
    return line[32*int'(word) +: 32];
  endfunction

`ifdef LINE_BUF_EN
  logic              bufValid_q, bufValid_d;
  logic [TAG_W-1:0]  bufTag_q, bufTag_d;
  logic [LINE_W-1:0] bufData_q, bufData_d;
  logic              bufHit;

  assign bufHit = bufValid_q && (bufTag_q == bus.cpu_addr[BYTE_ADDR_W-1:4]);
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    tag_d     = tag_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    reqAddr_d = reqAddr_q;
    reqData_d = reqData_q;
`ifdef LINE_BUF_EN
    bufValid_d = bufValid_q;
    bufTag_d   = bufTag_q;
    bufData_d  = bufData_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_valid) begin
          we_d      = bus.cpu_we;
          tag_d     = bus.cpu_addr[BYTE_ADDR_W-1:4];
          word_d    = bus.cpu_addr[3:2];
          wdata_d   = bus.cpu_wdata;
          be_d      = bus.cpu_be;
          reqAddr_d = {bus.cpu_addr[BYTE_ADDR_W-1:4], 3'b000};
          // A store that enables no bytes changes nothing, so it completes without DRAM traffic
          if (bus.cpu_we && bus.cpu_be == 4'b0000) begin
            state_d = RESP;
          end
`ifdef LINE_BUF_EN
          else if (bufHit && !bus.cpu_we) begin
            rdata_d = pickWord(bufData_q, bus.cpu_addr[3:2]);
            state_d = RESP;
          end else if (bufHit) begin
            reqData_d = mergeLine(bufData_q, bus.cpu_addr[3:2], bus.cpu_wdata, bus.cpu_be);
            state_d   = WR_REQ;
          end
`endif
          else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (bus.req_rdy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.rsp_en) begin
          if (we_q) begin
            reqData_d = mergeLine(bus.rsp_data, word_q, wdata_q, be_q);
            state_d   = WR_REQ;
          end else begin
            rdata_d = pickWord(bus.rsp_data, word_q);
            state_d = RESP;
          end
`ifdef LINE_BUF_EN
          bufValid_d = 1'b1;
          bufTag_d   = tag_q;
          bufData_d  = bus.rsp_data;
`endif
        end
      end
      WR_REQ: begin
        if (bus.req_rdy) begin
          state_d = RESP;
`ifdef LINE_BUF_EN
          bufValid_d = 1'b1;
          bufTag_d   = tag_q;
          bufData_d  = reqData_q;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      tag_q     <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      reqAddr_q <= '0;
      reqData_q <= '0;
`ifdef LINE_BUF_EN
      bufValid_q <= 1'b0;
      bufTag_q   <= '0;
      bufData_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      tag_q     <= tag_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      reqAddr_q <= reqAddr_d;
      reqData_q <= reqData_d;
`ifdef LINE_BUF_EN
      bufValid_q <= bufValid_d;
      bufTag_q   <= bufTag_d;
      bufData_q  <= bufData_d;
`endif
    end
  end

  assign bus.cpu_ready      = (state_q == IDLE);
  assign bus.cpu_resp_valid = (state_q == RESP);
  assign bus.cpu_rdata      = rdata_q;
  assign bus.req_en         = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign bus.req_cmd        = (state_q == RD_REQ);
  assign bus.req_addr       = reqAddr_q;
  assign bus.req_data       = reqData_q;
endmodule

// File: tb/tb_dram_word_port.sv
// Self-checking bench for dram_word_port: a DRAM controller model plus a word-memory reference model.
// Build with LINE_BUF_EN defined to also exercise the line buffer.
module tb_dram_word_port;
  localparam int BYTE_ADDR_W = 28;
  localparam int REQ_ADDR_W  = 27;
  localparam int LINE_W      = 128;
`ifdef LINE_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  dram_word_port_if #(.BYTE_ADDR_W(BYTE_ADDR_W), .REQ_ADDR_W(REQ_ADDR_W), .LINE_W(LINE_W)) bus ();

  dram_word_port #(.BYTE_ADDR_W(BYTE_ADDR_W), .REQ_ADDR_W(REQ_ADDR_W), .LINE_W(LINE_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Controller knobs (written by tests) and observations (written by the controller)
  bit          stallRdy = 1'b0;
  bit          randRdy = 1'b0;
  bit          randDelay = 1'b0;
  int          rspDelay = 3;
  int          injectReq = 0;
  int          injectDone = 0;
  int          rdCount = 0;
  int          wrCount = 0;
  int          rspCount = 0;
  int          pendAddr = 0;
  logic [26:0] lastRdAddr = '0;
  logic [26:0] lastWrAddr = '0;
  logic [127:0] lastWrData = '0;
  logic [127:0] dram [int];
  logic [127:0] initMem [int];
  logic [127:0] refMem [int];

  function automatic logic [127:0] dramLine(input int a);
    if (dram.exists(a)) return dram[a];
    if (initMem.exists(a)) return initMem[a];
    return '0;
  endfunction

  // Controller acts 1ns after each falling edge so tests changing knobs at the edge never race it
  initial begin
    bus.req_rdy  = 1'b0;
    bus.rsp_en   = 1'b0;
    bus.rsp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.rsp_en = 1'b0;
      if (injectDone != injectReq) begin
        injectDone   = injectReq;
        bus.rsp_en   = 1'b1;
        bus.rsp_data = {4{32'hDEADBEEF}};
      end
      if (rspCount > 0) begin
        rspCount--;
        if (rspCount == 0) begin
          bus.rsp_en   = 1'b1;
          bus.rsp_data = dramLine(pendAddr);
        end
      end
      if (stallRdy) bus.req_rdy = 1'b0;
      else if (randRdy) bus.req_rdy = 1'($urandom_range(0, 1));
      else bus.req_rdy = 1'b1;
      if (bus.req_en === 1'b1 && bus.req_rdy) begin
        if (bus.req_cmd) begin
          rdCount++;
          lastRdAddr = bus.req_addr;
          pendAddr   = int'(bus.req_addr);
          rspCount   = randDelay ? int'($urandom_range(1, 5)) : rspDelay;
        end else begin
          wrCount++;
          lastWrAddr = bus.req_addr;
          lastWrData = bus.req_data;
          dram[int'(bus.req_addr)] = bus.req_data;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic issueRequest(input logic we, input logic [27:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be);
    int guard = 0;
    @(negedge clk);
    while (bus.cpu_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("[TB] FAIL issue_ready: cpu_ready=%b after %0d cycles, required 1", bus.cpu_ready, guard);
    end
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_be    = be;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    bus.cpu_wdata = $urandom;
  endtask

  task automatic waitResponse(output bit got, output int latency, output logic [31:0] rdata,
                              output bit single);
    got = 1'b0; latency = 0; rdata = '0; single = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (bus.cpu_resp_valid === 1'b1) begin
        got = 1'b1; latency = c; rdata = bus.cpu_rdata;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      @(negedge clk);
      single = (bus.cpu_resp_valid === 1'b0);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cpu_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cpu_ready: got %b required 1", bus.cpu_ready); end
    checks++; if (bus.cpu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b required 0", bus.cpu_resp_valid); end
    checks++; if (bus.req_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_en: got %b required 0", bus.req_en); end
    checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h required 0", bus.cpu_rdata); end
    checks++; if (bus.req_addr !== 27'h0) begin errors++; $display("[TB] FAIL reset_req_addr: got %h required 0", bus.req_addr); end
    checks++; if (bus.req_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_req_data: got %h required 0", bus.req_data); end
    checks++; if (bus.req_cmd !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_cmd: got %b required 0", bus.req_cmd); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.cpu_ready !== 1'b1 || bus.req_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_release: ready=%b req_en=%b required 1/0", bus.cpu_ready, bus.req_en); end
  endtask

  task automatic test_load_basic();
    bit got, single; int lat; logic [31:0] rd; int rd0;
    initMem[27'h8] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    rd0 = rdCount;
    issueRequest(1'b0, 28'h0000010, 32'h0, 4'h0);
    checks++; if (bus.req_en !== 1'b1 || bus.req_cmd !== 1'b1) begin errors++; $display("[TB] FAIL load_req: req_en=%b req_cmd=%b required 1/1", bus.req_en, bus.req_cmd); end
    checks++; if (bus.req_addr !== 27'h8) begin errors++; $display("[TB] FAIL load_req_addr: got %h required %h", bus.req_addr, 27'h8); end
    waitResponse(got, lat, rd, single);
    checks++; if (!got || lat != 5) begin errors++; $display("[TB] FAIL load_latency: got resp=%0d after %0d cycles, required 5", got, lat); end
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("[TB] FAIL load_rdata: got %h required %h", rd, 32'h1111_1111); end
    checks++; if (!single) begin errors++; $display("[TB] FAIL load_single_pulse: pulse longer than one cycle"); end
    checks++; if (rdCount - rd0 != 1 || lastRdAddr !== 27'h8) begin errors++; $display("[TB] FAIL load_handshake: reads=%0d addr=%h required 1/%h", rdCount - rd0, lastRdAddr, 27'h8); end
  endtask

  task automatic test_store_merge();
    bit got, single; int lat; logic [31:0] rd; int rd0, wr0;
    initMem[27'h10] = {4{32'h1111_1111}};
    rd0 = rdCount; wr0 = wrCount;
    issueRequest(1'b1, 28'h0000028, 32'hAABB_CCDD, 4'b0101);
    waitResponse(got, lat, rd, single);
    checks++; if (!got || lat != 6) begin errors++; $display("[TB] FAIL store_latency: got resp=%0d after %0d cycles, required 6", got, lat); end
    checks++; if (wrCount - wr0 != 1 || rdCount - rd0 != 1) begin errors++; $display("[TB] FAIL store_handshakes: reads=%0d writes=%0d required 1/1", rdCount - rd0, wrCount - wr0); end
    checks++; if (lastWrData !== 128'h1111_1111_11BB_11DD_1111_1111_1111_1111) begin errors++; $display("[TB] FAIL store_line: got %h required %h", lastWrData, 128'h1111_1111_11BB_11DD_1111_1111_1111_1111); end
    checks++; if (lastWrAddr !== 27'h10) begin errors++; $display("[TB] FAIL store_addr: got %h required %h", lastWrAddr, 27'h10); end
    checks++; if (!single) begin errors++; $display("[TB] FAIL store_single_pulse: pulse longer than one cycle"); end
  endtask

  task automatic test_stall();
    bit got, single; int lat; logic [31:0] rd; int rd0; logic [127:0] line;
    line = {$urandom, $urandom, $urandom, $urandom};
    initMem[27'h180] = line;
    rd0 = rdCount;
    stallRdy = 1'b1;
    issueRequest(1'b0, 28'h0000308, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.req_en !== 1'b1 || bus.req_cmd !== 1'b1) begin errors++; $display("[TB] FAIL stall_req_en[%0d]: req_en=%b req_cmd=%b required 1/1", i, bus.req_en, bus.req_cmd); end
      checks++; if (bus.req_addr !== 27'h180) begin errors++; $display("[TB] FAIL stall_req_addr[%0d]: got %h required %h", i, bus.req_addr, 27'h180); end
      if (i < 4) @(negedge clk);
    end
    stallRdy = 1'b0;
    waitResponse(got, lat, rd, single);
    checks++; if (!got) begin errors++; $display("[TB] FAIL stall_resp: no response, required one"); end
    checks++; if (rd !== line[95:64]) begin errors++; $display("[TB] FAIL stall_rdata: got %h required %h", rd, line[95:64]); end
    checks++; if (rdCount - rd0 != 1) begin errors++; $display("[TB] FAIL stall_handshakes: got %0d required 1", rdCount - rd0); end
  endtask

  task automatic test_zero_be();
    bit got, single; int lat; logic [31:0] rd; int rd0, wr0;
    rd0 = rdCount; wr0 = wrCount;
    issueRequest(1'b1, 28'h0000700, $urandom, 4'b0000);
    checks++; if (bus.req_en !== 1'b0) begin errors++; $display("[TB] FAIL zero_be_req_en: got %b required 0", bus.req_en); end
    waitResponse(got, lat, rd, single);
    checks++; if (!got || lat != 1) begin errors++; $display("[TB] FAIL zero_be_latency: got resp=%0d after %0d cycles, required 1", got, lat); end
    checks++; if (!single) begin errors++; $display("[TB] FAIL zero_be_single_pulse: pulse longer than one cycle"); end
    checks++; if (rdCount != rd0 || wrCount != wr0) begin errors++; $display("[TB] FAIL zero_be_dram: reads=%0d writes=%0d required 0/0", rdCount - rd0, wrCount - wr0); end
    injectReq++;
    repeat (3) @(negedge clk);
    checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_resp_valid !== 1'b0 || bus.req_en !== 1'b0) begin errors++; $display("[TB] FAIL spurious_rsp: ready=%b resp=%b req_en=%b required 1/0/0", bus.cpu_ready, bus.cpu_resp_valid, bus.req_en); end
  endtask

  task automatic test_reset_mid();
    bit sawResp;
    initMem[27'h200] = {$urandom, $urandom, $urandom, $urandom};
    rspDelay = 6;
    issueRequest(1'b0, 28'h0000400, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.cpu_ready !== 1'b1 || bus.req_en !== 1'b0 || bus.cpu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state: ready=%b req_en=%b resp=%b required 1/0/0", bus.cpu_ready, bus.req_en, bus.cpu_resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    sawResp = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.cpu_resp_valid === 1'b1) sawResp = 1'b1;
    end
    checks++; if (sawResp) begin errors++; $display("[TB] FAIL mid_reset_resp: got a response pulse, required none"); end
    checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_idle: cpu_ready=%b required 1", bus.cpu_ready); end
    rspDelay = 3;
  endtask

`ifdef LINE_BUF_EN
  task automatic test_line_buf();
    bit got, single; int lat; logic [31:0] rd; int rd0, wr0; logic [127:0] line, expLine;
    logic [31:0] w;
    line = {$urandom, $urandom, $urandom, $urandom};
    w = $urandom;
    initMem[27'h280] = line;
    rd0 = rdCount; wr0 = wrCount;
    issueRequest(1'b0, 28'h0000504, 32'h0, 4'h0);
    waitResponse(got, lat, rd, single);
    checks++; if (!got || lat != 5 || rd !== line[63:32]) begin errors++; $display("[TB] FAIL buf_miss_load: lat=%0d rdata=%h required 5/%h", lat, rd, line[63:32]); end
    issueRequest(1'b0, 28'h000050C, 32'h0, 4'h0);
    checks++; if (bus.req_en !== 1'b0) begin errors++; $display("[TB] FAIL buf_hit_req_en: got %b required 0", bus.req_en); end
    waitResponse(got, lat, rd, single);
    checks++; if (!got || lat != 1 || rd !== line[127:96]) begin errors++; $display("[TB] FAIL buf_hit_load: lat=%0d rdata=%h required 1/%h", lat, rd, line[127:96]); end
    checks++; if (rdCount - rd0 != 1) begin errors++; $display("[TB] FAIL buf_hit_reads: got %0d required 1", rdCount - rd0); end
    expLine = line;
    expLine[95:64] = w;
    issueRequest(1'b1, 28'h0000508, w, 4'b1111);
    waitResponse(got, lat, rd, single);
    checks++; if (!got || lat != 2) begin errors++; $display("[TB] FAIL buf_hit_store_latency: got %0d required 2", lat); end
    checks++; if (rdCount - rd0 != 1 || wrCount - wr0 != 1 || lastWrData !== expLine) begin errors++; $display("[TB] FAIL buf_hit_store: reads=%0d writes=%0d line=%h required 1/1/%h", rdCount - rd0, wrCount - wr0, lastWrData, expLine); end
    issueRequest(1'b0, 28'h0000508, 32'h0, 4'h0);
    waitResponse(got, lat, rd, single);
    checks++; if (!got || lat != 1 || rd !== w) begin errors++; $display("[TB] FAIL buf_updated_load: lat=%0d rdata=%h required 1/%h", lat, rd, w); end
    issueRequest(1'b0, 28'h0000600, 32'h0, 4'h0);
    waitResponse(got, lat, rd, single);
    checks++; if (!got || lat != 5 || rdCount - rd0 != 2) begin errors++; $display("[TB] FAIL buf_other_line: lat=%0d reads=%0d required 5/2", lat, rdCount - rd0); end
  endtask
`endif

  task automatic test_random();
    bit got, single; int lat; logic [31:0] rd;
    int rd0, wr0, key, k, bufKey;
    bit bufValid, we, nontrivial, hit;
    logic [3:0] be; logic [31:0] wdata, mask, oldWord; logic [23:0] tag; logic [127:0] line;
    applyReset();
    bufValid = 1'b0; bufKey = 0;
    for (int i = 0; i < 8; i++) begin
      key = (32'h1000 + i) * 8;
      initMem[key] = {$urandom, $urandom, $urandom, $urandom};
      refMem[key]  = initMem[key];
    end
    randRdy = 1'b1; randDelay = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tag   = 24'h1000 + 24'($urandom_range(0, 7));
      key   = int'(tag) * 8;
      k     = $urandom_range(0, 3);
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom_range(0, 15));
      wdata = $urandom;
      nontrivial = !(we && be == 4'b0000);
      hit = BUF_EN && bufValid && (bufKey == key);
      rd0 = rdCount; wr0 = wrCount;
      issueRequest(we, {tag, 2'(k), 2'($urandom_range(0, 3))}, wdata, be);
      waitResponse(got, lat, rd, single);
      line = refMem[key];
      oldWord = line[32*k +: 32];
      checks++; if (!got || !single) begin errors++; $display("[TB] FAIL rand_resp[%0d]: got=%0d single=%0d required 1/1", t, got, single); end
      if (!we) begin
        checks++; if (rd !== oldWord) begin errors++; $display("[TB] FAIL rand_rdata[%0d]: got %h required %h", t, rd, oldWord); end
      end
      checks++; if (rdCount - rd0 != int'(nontrivial && !hit)) begin errors++; $display("[TB] FAIL rand_reads[%0d]: got %0d required %0d", t, rdCount - rd0, int'(nontrivial && !hit)); end
      checks++; if (wrCount - wr0 != int'(we && be != 4'b0000)) begin errors++; $display("[TB] FAIL rand_writes[%0d]: got %0d required %0d", t, wrCount - wr0, int'(we && be != 4'b0000)); end
      if (we) begin
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{be[b]}};
        line[32*k +: 32] = (oldWord & ~mask) | (wdata & mask);
        refMem[key] = line;
      end
      if (nontrivial) begin
        bufValid = 1'b1;
        bufKey   = key;
      end
    end
    randRdy = 1'b0; randDelay = 1'b0;
    for (int i = 0; i < 8; i++) begin
      key = (32'h1000 + i) * 8;
      checks++; if (dramLine(key) !== refMem[key]) begin errors++; $display("[TB] FAIL rand_dram_line[%0d]: got %h required %h", i, dramLine(key), refMem[key]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store_merge();
    test_stall();
    test_zero_be();
    test_reset_mid();
`ifdef LINE_BUF_EN
    test_line_buf();
`endif
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
